syn_fft_cache_arb: RTL
======================

Name: syn_fft_cache_arb

Overview:
- Shares one FFT cache RAM (one write port, one read port, fixed read latency) between the FFT butterfly datapath and the host register path.
- The FFT side has priority; host accesses fill idle slots, with a starvation guard that forces a host slot and stalls the FFT.
- Tags in-flight reads so each return is routed to the requester that issued it, and tracks cache-ready status from fft_done.

Parameters:
- DATA_W, 32, width of the cache word.
- ADDR_W, 8, cache address width; the low half holds LCHANNEL and the high half RCHANNEL.
- RD_LAT, 2, RAM read latency in cycles, from ram_rd_en to ram_rd_data valid.
- STARVE_LIM, 16, number of consecutive blocked cycles a pending host op tolerates before a forced slot.

Ports:
- clk_ir  in  1  clock
- rst_il  in  1  reset, asynchronous, active-low
- fft_wr_en  in  1  FFT write strobe
- fft_waddr  in  ADDR_W  FFT write address
- fft_wr_data  in  DATA_W  FFT write data
- fft_rd_en  in  1  FFT read strobe
- fft_raddr  in  ADDR_W  FFT read address
- fft_rd_data  out  DATA_W  FFT read return data
- fft_rd_valid  out  1  FFT read return valid
- fft_done  in  1  one-cycle pulse at end of transform
- fft_stall  out  1  FFT must issue no rd/wr this cycle
- hst_wr_en  in  1  host write pulse
- hst_rd_en  in  1  host read pulse
- hst_addr  in  ADDR_W  host address
- hst_wr_data  in  DATA_W  host write data
- hst_busy  out  1  host op pending; new host ops are illegal
- hst_rd_data  out  DATA_W  host read return data
- hst_rd_valid  out  1  host read return valid
- ram_wr_en  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_wr_data  out  DATA_W  RAM write data
- ram_rd_en  out  1  RAM read enable
- ram_raddr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data
- cache_rdy  out  1  cache holds a completed transform
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values (rst_il low, asynchronous): every output is 0; the pending buffer, starve counter and tag pipe are cleared. In-flight reads are discarded and never returned.
- RAM-side outputs are registered, so the RAM sees a granted op one cycle after it is accepted.
- FFT path: when fft_stall is 0, fft_wr_en/fft_rd_en pass straight to the RAM ports in the next cycle. Read and write ports are arbitrated independently.
- Host capture:
  - hst_wr_en or hst_rd_en while hst_busy=0 latches op, address and data into a 1-deep pending buffer; hst_busy rises the next cycle.
  - If both strobes arrive in the same cycle, the write wins and proto_err is set.
  - A host strobe while hst_busy=1 is dropped and proto_err is set.
- Host grant:
  - A pending host write is granted in any cycle with no fft_wr_en; a pending host read in any cycle with no fft_rd_en.
  - hst_busy falls the cycle after the grant.
- Starvation guard:
  - The starve counter increments on each cycle the host op is pending and blocked, and clears on grant.
  - When the counter reaches STARVE_LIM-1, fft_stall is registered high for exactly one cycle, and the host op is granted in that cycle.
  - Any FFT strobe during fft_stall=1 is dropped and proto_err is set.
- Read tag pipe: RD_LAT+1 stages of {valid, owner}, covering the registered request plus the RAM latency.
  - At the pipe output, ram_rd_data is registered into fft_rd_data or hst_rd_data, and the matching valid pulses for one cycle.
  - Total read latency from strobe to valid is RD_LAT+2 cycles, for both owners.
- cache_rdy: set the cycle after fft_done; cleared on the first granted FFT write. If fft_done coincides with an FFT write, set wins.
- proto_err clears only on reset.
- Same-address read and write in one cycle: RAM read-during-write returns old data; the arbiter adds no bypass.

Test Plan:
- Reset, then FFT writes 0x11..0x18 to addr 0..7 with no host traffic → ram_wr_en mirrors the strobes one cycle later; fft_stall stays 0.
- FFT idle, host write 0xDEADBEEF to addr 0x85, then host read of addr 0x85 → hst_busy high 1 cycle each; hst_rd_data=0xDEADBEEF with hst_rd_valid exactly RD_LAT+2 cycles after the read strobe.
- FFT reads every cycle while a host read is pending → after 15 blocked cycles fft_stall pulses for one cycle and the host read is granted in that slot; FFT reads resume and their returns stay correctly tagged.
- Host and FFT reads interleaved back-to-back → each return is routed to its issuer in issue order; no valid pulse appears on the wrong side.
- fft_done pulse, then an FFT write; separately, fft_done coinciding with an FFT write → cache_rdy goes 1 then 0 in the first case; cache_rdy=1 in the coincident case.
- Host strobe while hst_busy=1, and an FFT strobe during fft_stall → op dropped and proto_err=1; then assert rst_il with a read in flight → no valid pulse ever appears and all outputs are 0.

Source files
------------

// File: rtl/syn_fft_cache_arb.sv
// Shares one cache RAM between the FFT datapath (priority) and a 1-deep host op buffer.
// Reads return RD_LAT+2 cycles after issue; a host op blocked STARVE_LIM-1 cycles forces a one-cycle FFT stall.
module syn_fft_cache_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 16
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              fft_wr_en,
  input  logic [ADDR_W-1:0] fft_waddr,
  input  logic [DATA_W-1:0] fft_wr_data,
  input  logic              fft_rd_en,
  input  logic [ADDR_W-1:0] fft_raddr,
  output logic [DATA_W-1:0] fft_rd_data,
  output logic              fft_rd_valid,
  input  logic              fft_done,
  output logic              fft_stall,
  input  logic              hst_wr_en,
  input  logic              hst_rd_en,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wr_data,
  output logic              hst_busy,
  output logic [DATA_W-1:0] hst_rd_data,
  output logic              hst_rd_valid,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              cache_rdy,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_LIM - 2);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } hst_op_t;

  logic             pend;
  hst_op_t          pend_op;
  logic [CNT_W-1:0] starve_cnt;
  logic [RD_LAT:0]  tag_vld;
  logic [RD_LAT:0]  tag_hst;

  logic fft_wr_go;
  logic fft_rd_go;
  logic hst_wr_go;
  logic hst_rd_go;
  logic hst_go;
  logic hst_strobe;
  logic hst_cap;
  logic err_evt;
  logic stall_nxt;

  // A registered stall overrides FFT priority so the pending host op always wins that slot.
  assign fft_wr_go  = fft_wr_en & ~fft_stall;
  assign fft_rd_go  = fft_rd_en & ~fft_stall;
  assign hst_wr_go  = pend & pend_op.wr & (fft_stall | ~fft_wr_en);
  assign hst_rd_go  = pend & ~pend_op.wr & (fft_stall | ~fft_rd_en);
  assign hst_go     = hst_wr_go | hst_rd_go;
  assign hst_strobe = hst_wr_en | hst_rd_en;
  assign hst_cap    = hst_strobe & ~pend;
  assign err_evt    = (hst_wr_en & hst_rd_en) | (hst_strobe & pend) |
                      ((fft_wr_en | fft_rd_en) & fft_stall);
  assign stall_nxt  = pend & ~hst_go & (starve_cnt == CNT_PRE);
  assign hst_busy   = pend;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pend       <= 1'b0;
      pend_op    <= '0;
      starve_cnt <= '0;
      fft_stall  <= 1'b0;
    end else begin
      if (hst_cap) begin
        pend         <= 1'b1;
        pend_op.wr   <= hst_wr_en;
        pend_op.addr <= hst_addr;
        pend_op.dat  <= hst_wr_data;
      end else if (hst_go) begin
        pend <= 1'b0;
      end
      starve_cnt <= (pend && !hst_go) ? starve_cnt + CNT_W'(1) : '0;
      fft_stall  <= stall_nxt;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      ram_wr_en   <= 1'b0;
      ram_waddr   <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_raddr   <= '0;
    end else begin
      ram_wr_en   <= fft_wr_go | hst_wr_go;
      ram_waddr   <= hst_wr_go ? pend_op.addr : fft_waddr;
      ram_wr_data <= hst_wr_go ? pend_op.dat : fft_wr_data;
      ram_rd_en   <= fft_rd_go | hst_rd_go;
      ram_raddr   <= hst_rd_go ? pend_op.addr : fft_raddr;
    end
  end

  // Stage 0 lines up with ram_rd_en; stage RD_LAT lines up with valid ram_rd_data.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      tag_vld      <= '0;
      tag_hst      <= '0;
      fft_rd_valid <= 1'b0;
      fft_rd_data  <= '0;
      hst_rd_valid <= 1'b0;
      hst_rd_data  <= '0;
    end else begin
      tag_vld      <= {tag_vld[RD_LAT-1:0], fft_rd_go | hst_rd_go};
      tag_hst      <= {tag_hst[RD_LAT-1:0], hst_rd_go};
      fft_rd_valid <= tag_vld[RD_LAT] & ~tag_hst[RD_LAT];
      hst_rd_valid <= tag_vld[RD_LAT] & tag_hst[RD_LAT];
      if (tag_vld[RD_LAT] && !tag_hst[RD_LAT]) fft_rd_data <= ram_rd_data;
      if (tag_vld[RD_LAT] && tag_hst[RD_LAT])  hst_rd_data <= ram_rd_data;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      cache_rdy <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (fft_done)       cache_rdy <= 1'b1;
      else if (fft_wr_go) cache_rdy <= 1'b0;
      if (err_evt)        proto_err <= 1'b1;
    end
  end

endmodule
